sram_like_resp: RTL and testbench
=================================

SRAM_LIKE_RESP -- requirements
Module: sram_like_resp

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high; ports are named clk and rst.
REQ-002 Parameter ADDR_W, default 12, meaning word-address bits (memory depth 2^ADDR_W words).
REQ-003 Parameter RESP_LAT, default 2, meaning cycles from accept to data_ok; legal range 1..4.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 ben  in  4  byte enables; nonzero means request valid (reads drive 4'b1111).
REQ-007 addr  in  32  byte address; bits [1:0] ignored; word index = addr[ADDR_W+1:2], upper bits ignored (wrap).
REQ-008 wr  in  1  1 = write, 0 = read.
REQ-009 wdata  in  32  write data, byte lanes gated by ben.
REQ-010 addr_ok  out  1  request accepted this cycle.
REQ-011 data_ok  out  1  one-cycle response pulse, one per accepted request.
REQ-012 rdata  out  32  read data, valid only while data_ok.

Function
REQ-013 A request SHALL be accepted in a cycle where ben != 0 and addr_ok = 1; at most one accept per cycle.
REQ-014 addr_ok SHALL be combinational: ben != 0 AND (outstanding < 2 OR data_ok this cycle) AND no injected stall.
REQ-015 outstanding counter (0..2) SHALL increment on accept, decrement on data_ok, and be unchanged when both occur.
REQ-016 A write SHALL update the selected byte lanes of memory at the accept edge; other lanes are unchanged.
REQ-017 A read SHALL sample the memory word at accept, including a write accepted in any earlier cycle.
REQ-018 An accept at cycle T SHALL produce data_ok high for exactly cycle T+RESP_LAT, for reads and writes alike.
REQ-019 Responses SHALL be strictly in accept order; the fixed latency guarantees at most one data_ok per cycle.
REQ-020 rdata SHALL be 0 when data_ok is low and 0 on data_ok for a write response.
REQ-021 The response path SHALL be a RESP_LAT-deep shift pipeline of {valid, data} stages; there is no FSM beyond the optional stall generator.
REQ-022 With RESP_LAT >= 3, back-to-back accepts SHALL stall after two outstanding requests until the first data_ok.
REQ-023 A request with ben = 0 SHALL be ignored: addr_ok = 0, no state change.

Reset
REQ-024 While rst is high: addr_ok = 0, data_ok = 0, rdata = 0, outstanding = 0, pipeline valid bits cleared.
REQ-025 Reset mid-operation SHALL drop all in-flight responses; writes already accepted stay in memory; memory contents are not reset.

Configuration
REQ-026 Macro SRAM_RESP_STALL_EN defined: a 16-bit LFSR (seed 16'hACE1 at reset, taps 16,14,13,11) SHALL advance every cycle, and addr_ok SHALL be forced low when LFSR[1:0] == 2'b00.
REQ-027 Macro SRAM_RESP_STALL_EN undefined: no LFSR logic; addr_ok follows REQ-014 without injected stalls.

Structure
REQ-028 Package sram_resp_pkg SHALL hold RESP_LAT_MAX = 4, MAX_OUTSTANDING = 2, LFSR_SEED, and the response-stage struct {valid, data[31:0]}.
REQ-029 The memory array with byte-lane writes SHALL be the single sub-module sram_resp_ram (one write port, one read port, read sampled at accept).

Verification
REQ-030 Write addr=0x10, ben=4'b1111, wdata=0xDEADBEEF, then read 0x10 -> read data_ok two cycles after its accept with rdata=0xDEADBEEF.
REQ-031 Read 0x10 after a write with ben=4'b0011 and wdata=0x0000AAAA over 0xDEADBEEF -> rdata=0xDEADAAAA.
REQ-032 RESP_LAT=4, three back-to-back reads held valid -> accepts at T, T+1, then addr_ok low until T+4, third accept at T+4, data_ok at T+4, T+5, T+8.
REQ-033 Read addr=0x4010 with ADDR_W=12 -> same word as 0x0010 (wrap); addr=0x13 -> same word as 0x10.
REQ-034 Assert rst one cycle after a read accept -> no data_ok ever for that read; outstanding=0, addr_ok low during reset, high the cycle after reset with ben != 0.
REQ-035 With SRAM_RESP_STALL_EN, 1000 random requests -> every accept gets exactly one in-order data_ok; addr_ok is never high when LFSR[1:0] == 0; read data matches the reference memory model.

Source files
------------

// File: rtl/sram_resp_pkg.sv
// Shared constants and the response-stage payload for the SRAM-like responder.
package sram_resp_pkg;

    localparam int unsigned DATA_W          = 32;
    localparam int unsigned BEN_W           = 4;
    localparam int unsigned RESP_LAT_MAX    = 4;
    localparam int unsigned MAX_OUTSTANDING = 2;
    localparam int unsigned OUTST_W         = 2;
    localparam logic [15:0] LFSR_SEED       = 16'hACE1;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] data;
    } resp_stage_t;

endpackage

// File: rtl/sram_like_resp_if.sv
// Request/response bus between a requester (master) and the SRAM-like responder (slave).
interface sram_like_resp_if;
    import sram_resp_pkg::*;

    logic [BEN_W-1:0]  ben;
    logic [31:0]       addr;
    logic              wr;
    logic [DATA_W-1:0] wdata;
    logic              addr_ok;
    logic              data_ok;
    logic [DATA_W-1:0] rdata;

    modport master (
        output ben, addr, wr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  ben, addr, wr, wdata,
        output addr_ok, data_ok, rdata
    );

endinterface

// File: rtl/sram_resp_ram.sv
// Word memory with byte-lane writes and a read port registered at the accept edge.
module sram_resp_ram
    import sram_resp_pkg::*;
#(
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] idx_i,
    input  logic [BEN_W-1:0]  ben_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;

    // Contents survive reset; only the enabled lanes are written.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int unsigned b = 0; b < BEN_W; b++) begin
                if (ben_i[b]) begin
                    mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Non-read cycles load zero so downstream stages carry zero data for writes.
    always_comb begin
        rdata_d = '0;
        if (re_i) begin
            rdata_d = mem_q[idx_i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sram_like_resp.sv
// Fixed-latency SRAM-like responder; define SRAM_RESP_STALL_EN for LFSR-driven accept stalls.
module sram_like_resp
    import sram_resp_pkg::*;
#(
    parameter int unsigned ADDR_W   = 12,
    parameter int unsigned RESP_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    sram_like_resp_if.slave  bus
);

    logic               stall_c;
    logic               data_ok_c;
    logic               addr_ok_c;
    logic [OUTST_W-1:0] outst_q;
    logic [OUTST_W-1:0] outst_d;
    logic               acc_q;
    logic               acc_d;
    logic [DATA_W-1:0]  ram_rdata;
    logic [ADDR_W-1:0]  word_idx;
    resp_stage_t        head_c;
    resp_stage_t        tail_c;
    logic               unused_addr_bits;

    assign word_idx         = bus.addr[ADDR_W+1:2];
    assign unused_addr_bits = ^{bus.addr[31:ADDR_W+2], bus.addr[1:0]};

`ifdef SRAM_RESP_STALL_EN
    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    assign lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign stall_c = (lfsr_q[1:0] == 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign stall_c = 1'b0;
`endif

    // A response retiring this cycle frees a slot for a same-cycle accept.
    assign data_ok_c = tail_c.valid & ~rst;
    assign addr_ok_c = ~rst && (bus.ben != '0) && ~stall_c &&
                       ((outst_q < OUTST_W'(MAX_OUTSTANDING)) || data_ok_c);

    assign bus.addr_ok = addr_ok_c;
    assign bus.data_ok = data_ok_c;
    assign bus.rdata   = data_ok_c ? tail_c.data : '0;

    always_comb begin
        outst_d = outst_q;
        acc_d   = addr_ok_c;
        if (addr_ok_c && !data_ok_c) begin
            outst_d = outst_q + OUTST_W'(1);
        end else if (!addr_ok_c && data_ok_c) begin
            outst_d = outst_q - OUTST_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            outst_q <= '0;
            acc_q   <= 1'b0;
        end else begin
            outst_q <= outst_d;
            acc_q   <= acc_d;
        end
    end

    sram_resp_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (addr_ok_c & bus.wr),
        .re_i    (addr_ok_c & ~bus.wr),
        .idx_i   (word_idx),
        .ben_i   (bus.ben),
        .wdata_i (bus.wdata),
        .rdata_o (ram_rdata)
    );

    // First response stage: accept flag and the RAM's registered read word.
    always_comb begin
        head_c       = '0;
        head_c.valid = acc_q;
        head_c.data  = ram_rdata;
    end

    if (RESP_LAT <= 1) begin : g_lat1
        assign tail_c = head_c;
    end else begin : g_pipe
        localparam int unsigned DEPTH = RESP_LAT - 1;

        resp_stage_t pipe_q [DEPTH];
        resp_stage_t pipe_d [DEPTH];

        always_comb begin
            pipe_d[0] = head_c;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                pipe_d[i] = pipe_q[i-1];
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    pipe_q[i] <= '0;
                end
            end else begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    pipe_q[i] <= pipe_d[i];
                end
            end
        end

        assign tail_c = pipe_q[DEPTH-1];
    end

endmodule

// File: tb/tb_sram_like_resp.sv
// Scoreboard bench for sram_like_resp: a RESP_LAT=2 instance for data paths, a RESP_LAT=4 one for stall timing.
module tb_sram_like_resp;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sram_like_resp_if if0 ();
    sram_like_resp_if if1 ();

    sram_like_resp #(.ADDR_W(12), .RESP_LAT(2)) u_dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
    sram_like_resp #(.ADDR_W(12), .RESP_LAT(4)) u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

    typedef struct {
        int          due;
        logic [31:0] data;
    } exp_t;

    exp_t        sbq[$];
    int          dok1[$];
    logic [31:0] model [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops one expectation per data_ok and checks timing and data.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (if0.data_ok) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_data_ok", 32'd1, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("resp_cycle", cyc, e.due);
                    chk("rdata", if0.rdata, e.data);
                end
            end else begin
                chk("rdata_idle", if0.rdata, 32'h0);
                if (sbq.size() != 0 && sbq[0].due <= cyc) begin
                    chk("missing_data_ok", 32'd0, 32'd1);
                    void'(sbq.pop_front());
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && if1.data_ok) dok1.push_back(cyc);
    end

    // Drive one request on if0 until accepted; expected response enters the scoreboard.
    task automatic issue(input logic w, input logic [31:0] a, input logic [3:0] be,
                         input logic [31:0] wd, input logic [31:0] exp);
        int  n = 0;
        bit  done = 0;
        if0.wr    = w;
        if0.addr  = a;
        if0.ben   = be;
        if0.wdata = wd;
        while (!done && n < 50) begin
            @(negedge clk);
            if (if0.addr_ok) begin
                sbq.push_back('{due: cyc + 2, data: (w ? 32'h0 : exp)});
                done = 1;
            end
            @(posedge clk); #1;
            n++;
        end
        if (!done) chk("accept_timeout", 32'd0, 32'd1);
        if0.ben = 4'h0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sbq.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (sbq.size() != 0) chk("drain_timeout", 32'(sbq.size()), 32'd0);
    endtask

    initial begin
        int          acc[$];
        logic [31:0] mask;
        logic [31:0] wd;
        logic [3:0]  be;
        int          k;

        rst = 1'b1;
        if0.ben = 4'hF; if0.wr = 1'b0; if0.addr = 32'h10; if0.wdata = '0;
        if1.ben = 4'hF; if1.wr = 1'b0; if1.addr = 32'h10; if1.wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_addr_ok", 32'(if0.addr_ok), 32'd0);
        chk("rst_data_ok", 32'(if0.data_ok), 32'd0);
        chk("rst_rdata", if0.rdata, 32'h0);
        chk("rst_addr_ok_lat4", 32'(if1.addr_ok), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        if0.ben = 4'h0;
        if1.ben = 4'h0;
        @(posedge clk); #1;

        // Full write then read back; partial-lane overwrite; address wrap and low-bit aliasing.
        issue(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 32'h0);
        issue(1'b0, 32'h10, 4'hF, 32'h0, 32'hDEADBEEF);
        issue(1'b1, 32'h10, 4'h3, 32'h0000AAAA, 32'h0);
        issue(1'b0, 32'h10, 4'hF, 32'h0, 32'hDEADAAAA);
        issue(1'b0, 32'h4010, 4'hF, 32'h0, 32'hDEADAAAA);
        issue(1'b0, 32'h13, 4'hF, 32'h0, 32'hDEADAAAA);
        wait_drain();

        issue(1'b1, 32'h20, 4'hF, 32'h11223344, 32'h0);
        issue(1'b1, 32'h20, 4'h8, 32'hAA000000, 32'h0);
        issue(1'b1, 32'h20, 4'h4, 32'h00BB0000, 32'h0);
        issue(1'b0, 32'h20, 4'hF, 32'h0, 32'hAABB3344);

        // ben = 0 must be ignored, even as a write.
        if0.wr = 1'b1; if0.addr = 32'h20; if0.wdata = 32'hFFFFFFFF; if0.ben = 4'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("ben0_addr_ok", 32'(if0.addr_ok), 32'd0);
            @(posedge clk); #1;
        end
        issue(1'b0, 32'h20, 4'hF, 32'h0, 32'hAABB3344);
        wait_drain();

        // Reset one cycle after a read accept: its response is dropped, memory kept.
        issue(1'b0, 32'h10, 4'hF, 32'h0, 32'hDEADAAAA);
        rst = 1'b1;
        sbq.delete();
        if0.ben = 4'hF; if0.wr = 1'b0; if0.addr = 32'h10;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("midrst_addr_ok", 32'(if0.addr_ok), 32'd0);
            chk("midrst_data_ok", 32'(if0.data_ok), 32'd0);
            @(posedge clk); #1;
        end
        rst = 1'b0;
        @(negedge clk);
`ifndef SRAM_RESP_STALL_EN
        chk("postrst_addr_ok", 32'(if0.addr_ok), 32'd1);
        if (if0.addr_ok) sbq.push_back('{due: cyc + 2, data: 32'hDEADAAAA});
        @(posedge clk); #1;
        if0.ben = 4'h0;
`else
        @(posedge clk); #1;
        if0.ben = 4'h0;
        issue(1'b0, 32'h10, 4'hF, 32'h0, 32'hDEADAAAA);
`endif
        repeat (6) @(posedge clk);
        #1;
        wait_drain();

        // Preload a small window, then random traffic checked against the model.
        for (int i = 0; i < 16; i++) begin
            wd = $urandom;
            issue(1'b1, 32'h100 + 32'(4 * i), 4'hF, wd, 32'h0);
            model[i] = wd;
        end
        for (int n = 0; n < 150; n++) begin
            k = int'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                wd = $urandom;
                be = 4'($urandom_range(1, 15));
                mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
                issue(1'b1, 32'h100 + 32'(4 * k), be, wd, 32'h0);
                model[k] = (model[k] & ~mask) | (wd & mask);
            end else begin
                issue(1'b0, 32'h100 + 32'(4 * k), 4'hF, 32'h0, model[k]);
            end
        end
        wait_drain();

        // RESP_LAT=4: three reads held valid, two-outstanding limit.
        dok1.delete();
        if1.ben = 4'hF; if1.wr = 1'b0; if1.addr = 32'h40;
        for (int n = 0; n < 40 && acc.size() < 3; n++) begin
            @(negedge clk);
            if (if1.addr_ok) acc.push_back(cyc);
            @(posedge clk); #1;
        end
        if1.ben = 4'h0;
        repeat (12) @(posedge clk);
        #1;
        chk("lat4_accepts", 32'(acc.size()), 32'd3);
        chk("lat4_data_oks", 32'(dok1.size()), 32'd3);
        if (acc.size() == 3 && dok1.size() == 3) begin
`ifndef SRAM_RESP_STALL_EN
            chk("lat4_acc1", 32'(acc[1] - acc[0]), 32'd1);
            chk("lat4_acc2", 32'(acc[2] - acc[0]), 32'd4);
`endif
            chk("lat4_dok0", 32'(dok1[0] - acc[0]), 32'd4);
            chk("lat4_dok1", 32'(dok1[1] - acc[1]), 32'd4);
            chk("lat4_dok2", 32'(dok1[2] - acc[2]), 32'd4);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
